// File: rtl/uart_receiver_custom.sv
`timescale 1ns/1ps
// uart_receiver_custom: 8N1 UART receiver, 2-flop synchronizer, mid-bit sampling, registered outputs.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote of the samples at counter MID-1, MID, MID+1.
module uart_receiver_custom #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned MID   = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx_sync;
  logic [1:0]       r_settle;
  logic             r_armed;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_data;
  logic [7:0]       w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_frame_err;
  logic             w_frame_err_nxt;
  logic             r_busy;

  logic             w_cnt_wrap;
  logic             w_sample_pt;
  logic             w_sample_bit;

  // Two-flop synchronizer; the raw line is seen nowhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_serial_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_sync = r_sync2;

  // After reset the synchronizer must refill and see an idle-high line before a start edge counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != 2'd2) begin
        r_settle <= r_settle + 2'd1;
      end
      if ((r_settle == 2'd2) && w_rx_sync) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_cnt_wrap = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

`ifdef UART_RX_MAJORITY_EN
  logic r_maj_a;
  logic r_maj_b;

  // Early samples for the vote; the third is the live synchronized value at MID+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_maj_a <= 1'b1;
      r_maj_b <= 1'b1;
    end else begin
      if (r_cnt == CNT_W'(MID - 1)) begin
        r_maj_a <= w_rx_sync;
      end
      if (r_cnt == CNT_W'(MID)) begin
        r_maj_b <= w_rx_sync;
      end
    end
  end

  assign w_sample_pt  = (r_cnt == CNT_W'(MID + 1));
  assign w_sample_bit = (r_maj_a & r_maj_b) | (r_maj_a & w_rx_sync) | (r_maj_b & w_rx_sync);
`else
  assign w_sample_pt  = (r_cnt == CNT_W'(MID));
  assign w_sample_bit = w_rx_sync;
`endif

  // Next-state and output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_armed && !w_rx_sync) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_sample_pt && w_sample_bit) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_wrap) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_sample_pt) begin
          w_shift_nxt = {w_sample_bit, r_shift[7:1]};
        end
        if (w_cnt_wrap) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        // Decide at the sample point and drop the rest of the stop bit.
        if (w_sample_pt) begin
          if (w_sample_bit) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = r_busy;

endmodule

// File: tb/tb_uart_receiver_custom.sv
`timescale 1ns/1ps
// tb_uart_receiver_custom: drives serial waveforms and compares every cycle against a waveform-level model.
module tb_uart_receiver_custom;

  localparam int CPB = 10;
  localparam int MID = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Input-sample index (relative to a bit's first cycle) at which the receiver decides.
  localparam int K = MID + 1 + MAJ;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int n_cmp;
  int n_fail;

  bit         w_log[$];
  logic       obs_valid[$];
  logic       obs_err[$];
  logic       obs_busy[$];
  logic [7:0] obs_data[$];

  logic [7:0] exp_last_data;
  int         g_nv;
  int         g_ne;
  int         g_first_vidx;
  logic [7:0] g_vbytes[$];

  uart_receiver_custom #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial_in (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: drive the line, log what the edge sampled and what the outputs show after it.
  task automatic cyc(input bit v);
    rx_in = v;
    @(posedge clk);
    w_log.push_back(v);
    #1;
    obs_valid.push_back(rx_valid);
    obs_err.push_back(rx_frame_err);
    obs_busy.push_back(rx_busy);
    obs_data.push_back(rx_data);
    n_cmp++;
    if ((rx_valid && rx_frame_err) !== 1'b0) begin
      n_fail++;
      $display("FAIL both_pulses: valid=%b frame_err=%b, required not both", rx_valid, rx_frame_err);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic clear_logs();
    w_log.delete();
    obs_valid.delete();
    obs_err.delete();
    obs_busy.delete();
    obs_data.delete();
  endtask

  // 8N1 frame, LSB first; inv flips the line for one cycle at that frame-relative index (-1: none).
  task automatic send_frame(input logic [7:0] b, input bit stop_v, input int inv);
    bit v;
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < CPB; c++) begin
        if (p == 0) v = 1'b0;
        else if (p == 9) v = stop_v;
        else v = b[p-1];
        if (p * CPB + c == inv) v = ~v;
        cyc(v);
      end
    end
  endtask

  // Line value the receiver takes for frame position pos of a frame whose first low sample is s.
  function automatic bit samp(input int s, input int pos);
    int a;
    a = s + pos * CPB + MID;
    if (MAJ != 0) return (int'(w_log[a]) + int'(w_log[a+1]) + int'(w_log[a+2])) >= 2;
    else return w_log[a+1];
  endfunction

  // Model frames from the logged line, then compare valid/err/data on every logged cycle.
  task automatic scoreboard_log(input string tag);
    int         ev_idx[$];
    bit         ev_err[$];
    logic [7:0] ev_byte[$];
    int         n, i, s, e;
    bit         armed, ev, ee;
    logic [7:0] byt, cur;
    n = w_log.size();
    i = 0;
    armed = 1'b0;
    while (i < n) begin
      if (!armed || w_log[i]) begin
        if (w_log[i]) armed = 1'b1;
        i++;
      end else begin
        s = i;
        if (s + 10 * CPB + 2 > n) begin
          i = n;
        end else if (samp(s, 0)) begin
          i = s + K + 1;
        end else begin
          for (int b = 0; b < 8; b++) byt[b] = samp(s, b + 1);
          ev_idx.push_back(s + 9 * CPB + K + 2);
          ev_err.push_back(!samp(s, 9));
          ev_byte.push_back(byt);
          i = s + 9 * CPB + K + 1;
        end
      end
    end
    cur = exp_last_data;
    e = 0;
    g_nv = 0;
    g_ne = 0;
    g_first_vidx = -1;
    g_vbytes.delete();
    for (int k = 0; k < n; k++) begin
      ev = 1'b0;
      ee = 1'b0;
      if (e < ev_idx.size() && ev_idx[e] == k) begin
        if (ev_err[e]) ee = 1'b1;
        else begin
          ev = 1'b1;
          cur = ev_byte[e];
        end
        e++;
      end
      n_cmp++;
      if (obs_valid[k] !== ev) begin
        n_fail++;
        $display("FAIL %s_valid cyc=%0d: got %b expected %b", tag, k, obs_valid[k], ev);
      end
      n_cmp++;
      if (obs_err[k] !== ee) begin
        n_fail++;
        $display("FAIL %s_frame_err cyc=%0d: got %b expected %b", tag, k, obs_err[k], ee);
      end
      n_cmp++;
      if (obs_data[k] !== cur) begin
        n_fail++;
        $display("FAIL %s_data cyc=%0d: got %h expected %h", tag, k, obs_data[k], cur);
      end
      if (obs_valid[k] === 1'b1) begin
        g_nv++;
        g_vbytes.push_back(obs_data[k]);
        if (g_first_vidx < 0) g_first_vidx = k;
      end
      if (obs_err[k] === 1'b1) g_ne++;
    end
    exp_last_data = cur;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_valid, rx_frame_err, rx_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {rx_valid, rx_frame_err, rx_busy});
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 00", rx_data);
    end
    rst = 1'b0;
    exp_last_data = 8'h00;
  endtask

  task automatic test_default_frame();
    int s;
    clear_logs();
    idle(4);
    s = w_log.size();
    send_frame(8'hA5, 1'b1, -1);
    idle(2 * CPB);
    scoreboard_log("default");
    n_cmp++;
    if (g_nv != 1 || g_ne != 0) begin
      n_fail++;
      $display("FAIL default_count: got valid=%0d err=%0d expected 1/0", g_nv, g_ne);
    end
    n_cmp++;
    if (g_first_vidx - s + 1 != 9 * CPB + MID + 4 + MAJ) begin
      n_fail++;
      $display("FAIL default_latency: got cycle %0d expected %0d", g_first_vidx - s + 1, 9 * CPB + MID + 4 + MAJ);
    end
    n_cmp++;
    if (obs_busy[s + 5] !== 1'b1 || obs_busy[obs_busy.size() - 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL default_busy: got mid=%b end=%b expected 1/0", obs_busy[s + 5], obs_busy[obs_busy.size() - 1]);
    end
    n_cmp++;
    if (rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL default_data: got %h expected a5", rx_data);
    end
  endtask

  task automatic test_frame_err();
    clear_logs();
    idle(4);
    send_frame(8'h55, 1'b0, -1);
    idle(3 * CPB);
    scoreboard_log("frame_err");
    n_cmp++;
    if (g_ne != 1 || g_nv != 0) begin
      n_fail++;
      $display("FAIL frame_err_count: got err=%0d valid=%0d expected 1/0", g_ne, g_nv);
    end
    n_cmp++;
    if (rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL frame_err_data: got %h expected a5", rx_data);
    end
  endtask

  task automatic test_false_start();
    int s;
    clear_logs();
    idle(4);
    s = w_log.size();
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    idle(3 * CPB);
    scoreboard_log("false_start");
    n_cmp++;
    if (obs_busy[s + 2] !== 1'b1) begin
      n_fail++;
      $display("FAIL false_start_busy_rise: got %b expected 1", obs_busy[s + 2]);
    end
    n_cmp++;
    if (obs_busy[s + 3 + MID + 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL false_start_busy_drop: got %b expected 0", obs_busy[s + 3 + MID + 1]);
    end
    n_cmp++;
    if (g_nv != 0 || g_ne != 0) begin
      n_fail++;
      $display("FAIL false_start_pulses: got valid=%0d err=%0d expected 0/0", g_nv, g_ne);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h3C;
    clear_logs();
    idle(4);
    for (int f = 0; f < 3; f++) send_frame(exp_b[f], 1'b1, -1);
    idle(2 * CPB);
    scoreboard_log("loopback");
    n_cmp++;
    if (g_nv != 3 || g_ne != 0) begin
      n_fail++;
      $display("FAIL loopback_count: got valid=%0d err=%0d expected 3/0", g_nv, g_ne);
    end else begin
      for (int f = 0; f < 3; f++) begin
        n_cmp++;
        if (g_vbytes[f] !== exp_b[f]) begin
          n_fail++;
          $display("FAIL loopback_byte%0d: got %h expected %h", f, g_vbytes[f], exp_b[f]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int lowrun;
    clear_logs();
    idle(4);
    for (int c = 0; c < 5 * CPB + 3; c++) cyc(1'b0);
    scoreboard_log("pre_reset");
    n_cmp++;
    if (obs_busy[obs_busy.size() - 1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_busy: got %b expected 1", obs_busy[obs_busy.size() - 1]);
    end
    rst = 1'b1;
    rx_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({rx_valid, rx_frame_err, rx_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b expected 000", {rx_valid, rx_frame_err, rx_busy});
    end
    exp_last_data = 8'h00;
    clear_logs();
    lowrun = (CPB - 4) + 3 * CPB;
    for (int c = 0; c < lowrun; c++) cyc(1'b0);
    idle(CPB + 4);
    send_frame(8'h81, 1'b1, -1);
    idle(2 * CPB);
    scoreboard_log("post_reset");
    for (int c = 0; c < lowrun; c++) begin
      n_cmp++;
      if (obs_busy[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_busy cyc=%0d: got %b expected 0", c, obs_busy[c]);
      end
    end
    n_cmp++;
    if (g_nv != 1 || g_ne != 0 || rx_data !== 8'h81) begin
      n_fail++;
      $display("FAIL post_reset_frame: got valid=%0d err=%0d data=%h expected 1/0/81", g_nv, g_ne, rx_data);
    end
  endtask

  task automatic test_majority();
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'hF0;
`else
    exp_d = 8'hF1;
`endif
    clear_logs();
    idle(4);
    send_frame(8'hF0, 1'b1, CPB + MID + 1);
    idle(2 * CPB);
    scoreboard_log("majority");
    n_cmp++;
    if (g_nv != 1 || rx_data !== exp_d) begin
      n_fail++;
      $display("FAIL majority_data: got valid=%0d data=%h expected 1/%h", g_nv, rx_data, exp_d);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit stop_v;
    clear_logs();
    idle(4);
    for (int f = 0; f < 24; f++) begin
      b = 8'($urandom);
      stop_v = ($urandom_range(0, 5) != 0);
      send_frame(b, stop_v, -1);
      idle($urandom_range(0, 3));
    end
    idle(12 * CPB);
    scoreboard_log("random");
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    rx_in = 1'b1;
    exp_last_data = 8'h00;
    test_reset();
    test_default_frame();
    test_frame_err();
    test_false_start();
    test_back_to_back();
    test_reset_midframe();
    test_majority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver_custom.md
UART_RECEIVER_CUSTOM -- requirements
Module: uart_receiver_custom

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 10, system clocks per UART bit; legal range >= 4.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: rx_serial_in  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 SHALL have port: rx_data  output  8  last correctly framed byte.
REQ-006 SHALL have port: rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-007 SHALL have port: rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port: rx_busy  output  1  high while a frame is in progress.

Function
REQ-009 SHALL pass rx_serial_in through a 2-flop synchronizer (rx_sync); no other logic SHALL observe the raw input.
REQ-010 SHALL implement states IDLE, START, DATA, STOP; rx_busy = 1 exactly in START, DATA and STOP.
REQ-011 SHALL define MID = (CLKS_PER_BIT-1)/2 (integer), the per-bit sample point, and a bit counter that runs 0..CLKS_PER_BIT-1 and then wraps to 0.
REQ-012 SHALL exit IDLE on the first cycle rx_sync = 0: go to START with counter = 0.
REQ-013 SHALL check the start bit in START at the sample point: if it reads 1 (false start), return to IDLE with no pulse; if it reads 0, enter DATA at counter wrap.
REQ-014 SHALL shift one bit per bit period into a right-shifting register in DATA, LSB first, sampled at the sample point; it SHALL enter STOP at the wrap after the 8th bit.
REQ-015 SHALL decide the frame at the STOP sample point:
- stop = 1: load rx_data and pulse rx_valid on the next cycle.
- stop = 0: pulse rx_frame_err on the next cycle, leaving rx_data unchanged.
- Either way, return to IDLE on the decision cycle, so the remaining half stop bit is not waited out.
REQ-016 SHALL treat a line still low after a framing error as a new start bit (no break detection).
REQ-017 SHALL never assert rx_valid and rx_frame_err in the same cycle; each pulse SHALL be exactly one cycle wide.
REQ-018 SHALL hold rx_data stable between rx_valid pulses.
REQ-019 SHALL assert rx_valid at cycle 9*CLKS_PER_BIT+MID+4, counted from the first clock edge sampling rx_serial_in low (cycle 98 for default), single-sample mode.
REQ-020 SHALL accept back-to-back frames from uart_transmitter_custom (stop bit followed immediately by start bit) without loss.

Reset
REQ-021 SHALL, while rst = 1 at a clock edge:
- set state to IDLE and clear all counters;
- set the shift register and rx_data to 0x00;
- set both synchronizer flops to 1;
- set rx_valid, rx_frame_err and rx_busy to 0.
REQ-022 SHALL abort a frame in progress on reset mid-frame with no rx_valid or rx_frame_err pulse; reception SHALL restart only on a fresh falling edge after rst deasserts.

Configuration
REQ-023 SHALL support macro UART_RX_MAJORITY_EN:
- Defined: each sampled bit (start, data, stop) SHALL be the 2-of-3 majority of rx_sync at counter MID-1, MID and MID+1. The decision is taken at MID+1, so all REQ-019 timing shifts by +1 cycle.
- Undefined: a single sample at counter MID.

Verification
REQ-024 SHALL cover default frame: serial 0xA5 at CLKS_PER_BIT=10 -> rx_valid high for 1 cycle at cycle 98, rx_data=0xA5, rx_frame_err=0.
REQ-025 SHALL cover loopback: uart_transmitter_custom sends 0x00, 0xFF, 0x3C back-to-back -> three rx_valid pulses in order with matching rx_data, no rx_frame_err.
REQ-026 SHALL cover false start: 3-cycle low glitch on an idle line -> rx_busy drops by MID+1 cycles later, no rx_valid or rx_frame_err.
REQ-027 SHALL cover framing error: 0x55 sent with stop bit low -> rx_frame_err 1-cycle pulse, rx_valid stays 0, rx_data keeps its previous 0xA5.
REQ-028 SHALL cover reset mid-frame: rst for 1 cycle during data bit 4 -> rx_busy=0, no pulses; a next frame 0x81 -> rx_valid, rx_data=0x81.
REQ-029 SHALL cover the majority filter: frame 0xF0 with a 1-cycle inversion at counter MID of bit 0:
- with UART_RX_MAJORITY_EN -> rx_data=0xF0;
- without it -> rx_data=0xF1.
